mem_port_arbiter: RTL and testbench

//  Shares one single-ported memory between instruction fetch (port I, read-only) and the MEM stage (port D, read/write).

---
 rtl/mem_port_arbiter_pkg.sv | 57 +++++
 rtl/mem_port_arbiter_if.sv | 56 +++++
 rtl/mem_port_arbiter_counter.sv | 39 +++
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 4;

  // Byte mask used for every instruction fetch read
  localparam logic [MASK_W-1:0] IMEM_MASK = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // Command presented on the external memory bus
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] mask;
    logic              ren;
    logic              wen;
  } mem_cmd_t;

  // Bus command for an instruction fetch: always a full-word read
  function automatic mem_cmd_t imem_cmd(input logic [ADDR_W-1:0] addr);
    mem_cmd_t c;
    c.addr  = addr;
    c.wdata = '0;
    c.mask  = IMEM_MASK;
    c.ren   = 1'b1;
    c.wen   = 1'b0;
    return c;
  endfunction

  // Bus command for a data access; a read is simply "not a write"
  function automatic mem_cmd_t dmem_cmd(input logic [ADDR_W-1:0] addr,
                                        input logic [DATA_W-1:0] wdata,
                                        input logic [MASK_W-1:0] mask,
                                        input logic              wen);
    mem_cmd_t c;
    c.addr  = addr;
    c.wdata = wdata;
    c.mask  = mask;
    c.ren   = ~wen;
    c.wen   = wen;
    return c;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the fetch unit, the MEM stage, the arbiter and the memory bus.
interface mem_port_arbiter_if;
  import mem_arb_pkg::*;

  // Instruction fetch port
  logic              i_imem_req;
  logic [ADDR_W-1:0] i_imem_addr;
  logic [DATA_W-1:0] o_imem_rdata;
  logic              o_imem_done;
  logic              o_imem_stall;

  // Data (MEM stage) port
  logic              i_dmem_req;
  logic              i_dmem_wen;
  logic [ADDR_W-1:0] i_dmem_addr;
  logic [DATA_W-1:0] i_dmem_wdata;
  logic [MASK_W-1:0] i_dmem_mask;
  logic [DATA_W-1:0] o_dmem_rdata;
  logic              o_dmem_done;
  logic              o_dmem_stall;

  logic              o_err;

  // External memory bus
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [MASK_W-1:0] o_mem_mask;
  logic              o_mem_ren;
  logic              o_mem_wen;
  logic              i_mem_ready;
  logic              i_mem_rvalid;
  logic [DATA_W-1:0] i_mem_rdata;

  // Arbiter view
  modport slave (
    input  i_imem_req, i_imem_addr,
    output o_imem_rdata, o_imem_done, o_imem_stall,
    input  i_dmem_req, i_dmem_wen, i_dmem_addr, i_dmem_wdata, i_dmem_mask,
    output o_dmem_rdata, o_dmem_done, o_dmem_stall,
    output o_err,
    output o_mem_addr, o_mem_wdata, o_mem_mask, o_mem_ren, o_mem_wen,
    input  i_mem_ready, i_mem_rvalid, i_mem_rdata
  );

  // Requesters-plus-memory view
  modport master (
    output i_imem_req, i_imem_addr,
    input  o_imem_rdata, o_imem_done, o_imem_stall,
    output i_dmem_req, i_dmem_wen, i_dmem_addr, i_dmem_wdata, i_dmem_mask,
    input  o_dmem_rdata, o_dmem_done, o_dmem_stall,
    input  o_err,
    input  o_mem_addr, o_mem_wdata, o_mem_mask, o_mem_ren, o_mem_wen,
    output i_mem_ready, i_mem_rvalid, i_mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_counter.sv
// Saturating up-counter with synchronous clear and a limit-reached flag.
module arb_sat_counter #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic hit_c_o
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Flag decoded straight from the count register
  assign hit_c_o = (cnt_q == CNT_W'(LIMIT));

  // Next count: clear wins, increment stops at LIMIT
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !hit_c_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch (read-only)
// and the MEM stage (read/write). One transaction in flight; D has priority
// unless I has been passed over STARVE_LIMIT times in a row.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  mem_port_arbiter_if.slave   bus
);

  state_e            state_q;
  owner_e            owner_q;
  mem_cmd_t          cmd_q;
  logic [DATA_W-1:0] imem_rdata_q;
  logic [DATA_W-1:0] dmem_rdata_q;
  logic              imem_done_q;
  logic              dmem_done_q;
  logic              err_q;

  logic gnt_dmem;
  logic gnt_imem;
  logic starve_hit;
  logic starve_inc;
  logic starve_clr;
  logic to_hit;
  logic to_inc;
  logic to_clr;

  // Winner selection and counter control, evaluated every cycle
  always_comb begin
    gnt_dmem   = bus.i_dmem_req & ~(bus.i_imem_req & starve_hit);
    gnt_imem   = bus.i_imem_req & ~gnt_dmem;
    starve_inc = 1'b0;
    starve_clr = 1'b0;
    to_inc     = 1'b0;
    to_clr     = 1'b0;
    if (state_q == IDLE) begin
      // Only grants taken in IDLE move the starvation count
      starve_inc = gnt_dmem & bus.i_imem_req;
      starve_clr = gnt_imem | (gnt_dmem & ~bus.i_imem_req);
    end
    // The read timeout counts the accept cycle so the first WAIT cycle reads 1
    to_inc = (state_q == WAIT) ||
             ((state_q == REQ) && bus.i_mem_ready && !cmd_q.wen);
    to_clr = (state_q == IDLE) || (state_q == DONE);
  end

  arb_sat_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .clr_i   (starve_clr),
    .inc_i   (starve_inc),
    .hit_c_o (starve_hit)
  );

  arb_sat_counter #(
    .LIMIT (TIMEOUT)
  ) u_timeout_cnt (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .clr_i   (to_clr),
    .inc_i   (to_inc),
    .hit_c_o (to_hit)
  );

  // Transaction FSM with registered bus command, read data and completion pulses
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      owner_q      <= OWN_I;
      cmd_q        <= '0;
      imem_rdata_q <= '0;
      dmem_rdata_q <= '0;
      imem_done_q  <= 1'b0;
      dmem_done_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      imem_done_q <= 1'b0;
      dmem_done_q <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_dmem) begin
            owner_q <= OWN_D;
            cmd_q   <= dmem_cmd(bus.i_dmem_addr, bus.i_dmem_wdata,
                                bus.i_dmem_mask, bus.i_dmem_wen);
            state_q <= REQ;
          end else if (gnt_imem) begin
            owner_q <= OWN_I;
            cmd_q   <= imem_cmd(bus.i_imem_addr);
            state_q <= REQ;
          end
        end
        REQ: begin
          if (bus.i_mem_ready) begin
            cmd_q.ren <= 1'b0;
            cmd_q.wen <= 1'b0;
            if (cmd_q.wen) begin
              // Only D can write, so the done pulse goes straight to D
              dmem_done_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus.i_mem_rvalid) begin
            if (owner_q == OWN_D) begin
              dmem_rdata_q <= bus.i_mem_rdata;
              dmem_done_q  <= 1'b1;
            end else begin
              imem_rdata_q <= bus.i_mem_rdata;
              imem_done_q  <= 1'b1;
            end
            state_q <= DONE;
          end else if (to_hit) begin
            // Abort the read: zero data, flag the error alongside done
            if (owner_q == OWN_D) begin
              dmem_rdata_q <= '0;
              dmem_done_q  <= 1'b1;
            end else begin
              imem_rdata_q <= '0;
              imem_done_q  <= 1'b1;
            end
            err_q   <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Drive the bundle from the registers
  assign bus.o_mem_addr   = cmd_q.addr;
  assign bus.o_mem_wdata  = cmd_q.wdata;
  assign bus.o_mem_mask   = cmd_q.mask;
  assign bus.o_mem_ren    = cmd_q.ren;
  assign bus.o_mem_wen    = cmd_q.wen;
  assign bus.o_imem_rdata = imem_rdata_q;
  assign bus.o_imem_done  = imem_done_q;
  assign bus.o_dmem_rdata = dmem_rdata_q;
  assign bus.o_dmem_done  = dmem_done_q;
  assign bus.o_err        = err_q;

  // Stalls follow the request combinationally so the pipeline freezes at once
  assign bus.o_imem_stall = bus.i_imem_req & ~imem_done_q;
  assign bus.o_dmem_stall = bus.i_dmem_req & ~dmem_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a completion scoreboard.
module tb_mem_port_arbiter;

  localparam int unsigned STARVE_LIMIT = 4;
  localparam int unsigned TIMEOUT      = 64;

  typedef struct {
    logic        port;   // 1 = D, 0 = I
    logic        chk;    // compare read data
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   done_cnt;
  exp_t sb[$];

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req_v);
    total++;
    assert (obs === req_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, req_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic port, input logic chk, input logic [31:0] data, input logic err);
    exp_t e;
    e.port = port;
    e.chk  = chk;
    e.data = data;
    e.err  = err;
    sb.push_back(e);
  endtask

  // Wait for the next bus command, check its address, answer a read with rd.
  // Assumes i_mem_ready=1; returns in the DONE cycle.
  task automatic serve(input string tag, input logic [31:0] exp_addr, input logic [31:0] rd);
    int   n;
    logic is_rd;
    n = 0;
    while (!(bus.o_mem_ren || bus.o_mem_wen) && n < 20) begin
      step();
      n++;
    end
    check({tag, "_cmd_seen"}, 32'(n < 20), 32'd1);
    check({tag, "_addr"}, bus.o_mem_addr, exp_addr);
    is_rd = bus.o_mem_ren;
    step();
    if (is_rd) begin
      bus.i_mem_rvalid = 1'b1;
      bus.i_mem_rdata  = rd;
      step();
      bus.i_mem_rvalid = 1'b0;
    end
  endtask

  // Scoreboard: every done pulse must match the oldest pushed expectation
  always @(negedge clk) begin
    if (rst_n && (bus.o_imem_done || bus.o_dmem_done)) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        check("sb_empty", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("mon_port", {30'd0, bus.o_dmem_done, bus.o_imem_done}, e.port ? 32'd2 : 32'd1);
        if (e.chk) begin
          check("mon_rdata", e.port ? bus.o_dmem_rdata : bus.o_imem_rdata, e.data);
        end
        check("mon_err", 32'(bus.o_err), 32'(e.err));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int saved;
    total    = 0;
    bad      = 0;
    done_cnt = 0;
    rst_n    = 1'b0;
    bus.i_imem_req   = 1'b0;
    bus.i_imem_addr  = '0;
    bus.i_dmem_req   = 1'b0;
    bus.i_dmem_wen   = 1'b0;
    bus.i_dmem_addr  = '0;
    bus.i_dmem_wdata = '0;
    bus.i_dmem_mask  = '0;
    bus.i_mem_ready  = 1'b0;
    bus.i_mem_rvalid = 1'b0;
    bus.i_mem_rdata  = '0;
    step();
    step();

    // Reset state
    check("rst_ren", 32'(bus.o_mem_ren), 32'd0);
    check("rst_wen", 32'(bus.o_mem_wen), 32'd0);
    check("rst_addr", bus.o_mem_addr, 32'd0);
    check("rst_mask", 32'(bus.o_mem_mask), 32'd0);
    check("rst_done", {30'd0, bus.o_dmem_done, bus.o_imem_done}, 32'd0);
    check("rst_err", 32'(bus.o_err), 32'd0);
    rst_n = 1'b1;
    step();

    // 1: I read, ready on first cycle, rvalid one cycle later
    bus.i_imem_req  = 1'b1;
    bus.i_imem_addr = 32'h100;
    bus.i_mem_ready = 1'b1;
    push(1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    step();
    check("t1_ren", 32'(bus.o_mem_ren), 32'd1);
    check("t1_wen", 32'(bus.o_mem_wen), 32'd0);
    check("t1_addr", bus.o_mem_addr, 32'h100);
    check("t1_mask", 32'(bus.o_mem_mask), 32'hF);
    check("t1_stall", 32'(bus.o_imem_stall), 32'd1);
    step();
    check("t1_ren_drop", 32'(bus.o_mem_ren), 32'd0);
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'hDEADBEEF;
    step();
    bus.i_mem_rvalid = 1'b0;
    check("t1_done_lat", 32'(bus.o_imem_done), 32'd1);
    check("t1_rdata", bus.o_imem_rdata, 32'hDEADBEEF);
    check("t1_stall_rel", 32'(bus.o_imem_stall), 32'd0);
    bus.i_imem_req = 1'b0;
    step();
    check("t1_done_pulse", 32'(bus.o_imem_done), 32'd0);

    // 2: D write held off by ready=0 for three cycles
    bus.i_mem_ready  = 1'b0;
    bus.i_dmem_req   = 1'b1;
    bus.i_dmem_wen   = 1'b1;
    bus.i_dmem_addr  = 32'h2004;
    bus.i_dmem_wdata = 32'hCAFEF00D;
    bus.i_dmem_mask  = 4'b1100;
    push(1'b1, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t2_wen", 32'(bus.o_mem_wen), 32'd1);
      check("t2_ren", 32'(bus.o_mem_ren), 32'd0);
      check("t2_addr", bus.o_mem_addr, 32'h2004);
      check("t2_wdata", bus.o_mem_wdata, 32'hCAFEF00D);
      check("t2_mask", 32'(bus.o_mem_mask), 32'hC);
      check("t2_early_done", 32'(bus.o_dmem_done), 32'd0);
      if (i == 3) bus.i_mem_ready = 1'b1;
    end
    step();
    check("t2_done", 32'(bus.o_dmem_done), 32'd1);
    check("t2_wen_drop", 32'(bus.o_mem_wen), 32'd0);
    bus.i_dmem_req = 1'b0;
    step();

    // 3: simultaneous requests, D first then I
    bus.i_imem_req  = 1'b1;
    bus.i_imem_addr = 32'h300;
    bus.i_dmem_req  = 1'b1;
    bus.i_dmem_wen  = 1'b0;
    bus.i_dmem_addr = 32'h400;
    push(1'b1, 1'b1, 32'h11111111, 1'b0);
    push(1'b0, 1'b1, 32'h22222222, 1'b0);
    serve("t3_d", 32'h400, 32'h11111111);
    check("t3_istall_d_done", 32'(bus.o_imem_stall), 32'd1);
    bus.i_dmem_req = 1'b0;
    step();
    check("t3_istall_idle", 32'(bus.o_imem_stall), 32'd1);
    serve("t3_i", 32'h300, 32'h22222222);
    check("t3_istall_rel", 32'(bus.o_imem_stall), 32'd0);
    bus.i_imem_req = 1'b0;
    step();

    // 4: continuous D writes with I waiting: D,D,D,D,I,D
    bus.i_imem_req   = 1'b1;
    bus.i_imem_addr  = 32'h600;
    bus.i_dmem_req   = 1'b1;
    bus.i_dmem_wen   = 1'b1;
    bus.i_dmem_addr  = 32'h500;
    bus.i_dmem_wdata = 32'h55;
    bus.i_dmem_mask  = 4'hF;
    for (int i = 0; i < 4; i++) push(1'b1, 1'b0, 32'd0, 1'b0);
    push(1'b0, 1'b1, 32'h66660000, 1'b0);
    push(1'b1, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 4; i++) serve("t4_d", 32'h500, 32'd0);
    serve("t4_i", 32'h600, 32'h66660000);
    bus.i_imem_req = 1'b0;
    serve("t4_d_after", 32'h500, 32'd0);
    bus.i_dmem_req = 1'b0;
    step();

    // 5: D read never answered -> timeout abort
    bus.i_dmem_req  = 1'b1;
    bus.i_dmem_wen  = 1'b0;
    bus.i_dmem_addr = 32'h700;
    push(1'b1, 1'b1, 32'd0, 1'b1);
    step();
    check("t5_ren", 32'(bus.o_mem_ren), 32'd1);
    step();
    n = 0;
    while (!bus.o_dmem_done && n < 200) begin
      step();
      n++;
    end
    check("t5_wait_cycles", 32'(n), 32'(TIMEOUT));
    check("t5_err", 32'(bus.o_err), 32'd1);
    check("t5_rdata", bus.o_dmem_rdata, 32'd0);
    bus.i_dmem_req = 1'b0;
    step();
    check("t5_err_pulse", 32'(bus.o_err), 32'd0);
    check("t5_idle_ren", 32'(bus.o_mem_ren), 32'd0);

    // 6: async reset while waiting for read data, then a late rvalid
    bus.i_imem_req  = 1'b1;
    bus.i_imem_addr = 32'h800;
    step();
    step();
    saved = done_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_addr", bus.o_mem_addr, 32'd0);
    check("t6_async_mask", 32'(bus.o_mem_mask), 32'd0);
    check("t6_async_ren", 32'(bus.o_mem_ren), 32'd0);
    bus.i_imem_req = 1'b0;
    step();
    rst_n = 1'b1;
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'h0BADC0DE;
    step();
    bus.i_mem_rvalid = 1'b0;
    step();
    step();
    check("t6_no_done", 32'(done_cnt - saved), 32'd0);
    check("t6_rdata_clr", bus.o_imem_rdata, 32'd0);
    check("t6_ren_idle", 32'(bus.o_mem_ren), 32'd0);
    // Arbiter must be back in IDLE and serve a fresh fetch
    bus.i_imem_req  = 1'b1;
    bus.i_imem_addr = 32'h900;
    push(1'b0, 1'b1, 32'h90909090, 1'b0);
    serve("t6_after", 32'h900, 32'h90909090);
    bus.i_imem_req = 1'b0;
    step();
    step();

    check("end_sb_empty", 32'(sb.size()), 32'd0);
    check("end_done_cnt", 32'(done_cnt), 32'd12);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
